alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Round-robin arbiter sharing one combinational 5-bit ALU (alu: Y, Cout <- S, A, B) among NREQ requesters.
//  Muxes the winning requester's opcode/operands onto the ALU and registers Y/Cout.
//  Returns the result with the requester ID over a valid/ready response channel.
//  Sits between requesting units and the single ALU instance; the ALU is instantiated outside.
// PARAMETERS
//  NREQ  4  number of requesters, 2..8; requester index width IW = $clog2(NREQ)
//  DW    5  operand/result width (matches ALU A/B/Y)
//  SW    4  opcode width (matches ALU S)
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  rst_n      in   1        synchronous reset, active-low
//  req_valid  in   NREQ     per-requester request valid
//  req_ready  out  NREQ     per-requester accept; one-hot or zero
//  req_op     in   NREQ*SW  opcode of requester i at [SW*i +: SW]
//  req_a      in   NREQ*DW  operand A of requester i at [DW*i +: DW]
//  req_b      in   NREQ*DW  operand B of requester i at [DW*i +: DW]
//  alu_s      out  SW       to ALU S
//  alu_a      out  DW       to ALU A
//  alu_b      out  DW       to ALU B
//  alu_y      in   DW       from ALU Y
//  alu_cout   in   1        from ALU Cout
//  rsp_valid  out  1        response valid (registered)
//  rsp_ready  in   1        response consumer ready
//  rsp_id     out  IW       index of the requester that owns the response
//  rsp_y      out  DW       registered ALU result
//  rsp_cout   out  1        registered ALU carry
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_cout=0, rr_ptr=0.
//   A reset mid-operation drops the in-flight response without a handshake.
//  can_issue = (state==IDLE) | (rsp_valid & rsp_ready).
//  Winner: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//  Grant cycle (can_issue & |req_valid):
//   - req_ready[winner]=1 (combinational); the request is accepted in this cycle.
//   - alu_s/a/b = winner's fields.
//   - At posedge: rsp_y<=alu_y, rsp_cout<=alu_cout, rsp_id<=winner, rsp_valid<=1, rr_ptr<=(winner+1) mod NREQ, state<=BUSY.
//  No grant: req_ready=0 and alu_s/a/b=0. rr_ptr holds.
//  FSM: IDLE -> BUSY on a grant.
//   BUSY & ~rsp_ready: hold all response registers stable; no grant.
//   BUSY & rsp_ready & grant: back-to-back; stay BUSY with the new response.
//   BUSY & rsp_ready & no request: rsp_valid<=0, state<=IDLE.
//  Latency: response visible 1 cycle after the grant. Throughput: 1 op/cycle while rsp_ready=1.
//  Requesters must hold valid/op/a/b stable until req_ready. The arbiter does not check this.
//  Fairness: with all requesters valid, grants rotate 0,1,..,NREQ-1,0. Worst-case wait NREQ-1 grants.
//  Widths: no arithmetic in the arbiter. Y and Cout are passed through exactly as the ALU produces them.
// CONFIGURATION
//  ALU_ARB_PRIO_EN defined: requester 0 has strict priority and wins whenever req_valid[0]=1.
//   Other requesters are served round-robin among themselves. rr_ptr does not advance on a requester-0 grant.
//  ALU_ARB_PRIO_EN undefined: pure round-robin over all NREQ requesters, as described above.
// TESTING (bench instantiates alu and connects it to alu_* ports; NREQ=4)
//  1. rst_n=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, alu_a=0 throughout.
//  2. Only req 2: S=4'b0000, A=5'd26, B=5'd17 -> req_ready=4'b0100 in the same cycle.
//     Next cycle: rsp_valid=1, rsp_id=2, rsp_y/rsp_cout equal the alu outputs for (0000,26,17).
//  3. req_valid=4'b1111 held, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows one cycle later.
//  4. rsp_ready=0 for 3 cycles with req_valid=4'b0011 -> req_ready=0 and rsp_* stable.
//     On rsp_ready=1: a grant in that same cycle, then the next response the following cycle.
//  5. Assert rst_n=0 while rsp_valid=1 & rsp_ready=0 -> next cycle rsp_valid=0, state IDLE, first post-reset grant goes to req 0.
//  6. With ALU_ARB_PRIO_EN defined, req_valid=4'b1011 held -> req 0 granted every cycle; req 1/3 starve.
//     After req_valid[0] drops, grants alternate 1,3.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter that shares one combinational ALU (Y, Cout <- S, A, B)
// among NREQ requesters. The winning requester's opcode and operands are
// muxed onto the ALU. The ALU's Y/Cout are registered and returned together
// with the owning requester index over a valid/ready response channel.
//
// Handshakes (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised, the source holds
// valid and its payload stable until that transfer. req_ready is combinational
// and at most one-hot. rsp_valid/rsp_id/rsp_y/rsp_cout are registered.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     per-requester request handshake (NREQ bits)
//   req_op/a/b          packed per-requester opcode / operands
//   alu_s/a/b           to the external ALU (zero when nothing is granted)
//   alu_y/cout          from the external ALU
//   rsp_valid/ready     response handshake
//   rsp_id/y/cout       response payload
//
// Build option
//   ALU_ARB_PRIO_EN : requester 0 has strict priority. The other requesters
//                     share the round-robin pointer among themselves.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 5,
  parameter int SW   = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*SW-1:0] req_op,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [SW-1:0]    alu_s,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  input  logic [DW-1:0]    alu_y,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IW-1:0]    rsp_id,
  output logic [DW-1:0]    rsp_y,
  output logic             rsp_cout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   rr_ptr, rr_next;
  logic [IW-1:0]   winner;
  logic [NREQ-1:0] cand;
  logic            found;
  logic            can_issue;
  logic            grant;
  logic            rr_adv;

  // Reduces (pointer + offset) modulo NREQ to a requester index.
  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % NREQ);
  endfunction

  // Arbitration and next state.
  always_comb begin
    can_issue = (state == IDLE) || (rsp_valid && rsp_ready);
    cand      = req_valid;
    found     = 1'b0;
    winner    = '0;
`ifdef ALU_ARB_PRIO_EN
    // Requester 0 is taken out of the rotation and handled as an override.
    cand[0]   = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (!found && cand[wrap_idx(int'(rr_ptr) + k)]) begin
        found  = 1'b1;
        winner = wrap_idx(int'(rr_ptr) + k);
      end
    end
`ifdef ALU_ARB_PRIO_EN
    if (req_valid[0]) begin
      found  = 1'b1;
      winner = '0;
    end
    // A requester-0 win leaves the rotation untouched.
    rr_adv = !req_valid[0];
`else
    rr_adv = 1'b1;
`endif
    // Gating with rst_n keeps req_ready low during reset even before the
    // state register has seen its first edge.
    grant   = rst_n && can_issue && found;
    rr_next = (int'(winner) == NREQ - 1) ? '0 : winner + IW'(1);

    state_d = state;
    case (state)
      IDLE: if (grant) state_d = BUSY;
      BUSY: begin
        if (grant)          state_d = BUSY;
        else if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant and ALU operand mux; all zero when nothing is granted.
  always_comb begin
    req_ready = '0;
    alu_s     = '0;
    alu_a     = '0;
    alu_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (int'(winner) == i)) begin
        req_ready[i] = 1'b1;
        alu_s        = req_op[SW*i +: SW];
        alu_a        = req_a[DW*i +: DW];
        alu_b        = req_b[DW*i +: DW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Response registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      // rsp_valid mirrors BUSY; the payload only changes on a grant, so it
      // stays stable while the consumer stalls.
      rsp_valid <= (state_d == BUSY);
      if (grant) begin
        rsp_y    <= alu_y;
        rsp_cout <= alu_cout;
        rsp_id   <= winner;
        if (rr_adv) rr_ptr <= rr_next;
      end
    end
  end

endmodule
